// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and unified memory port signals.
// slave modport: arbiter side; master modport: core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic              d_ext_sign;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_ext_sign,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_ext_sign,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: data has fixed priority over fetch, one
// outstanding access at a time, variable-latency mem_ready handshake,
// byte-enable / store-lane generation and load alignment + extension.
// Optional macro MISALIGN_TRAP_EN: misaligned data accesses are answered
// immediately with d_err and never reach memory.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic       r_gnt_d;
    logic [1:0] r_lane;
    logic [1:0] r_size;
    logic       r_sign;

    logic [1:0] w_lane;
    logic       w_misalign;

    // Lane actually used: low address bits that don't fit the size are dropped
    function automatic logic [1:0] f_lane(input logic [1:0] a, input logic [1:0] size);
        case (size)
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_wrep(input logic [DATA_W-1:0] w, input logic [1:0] size);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_load(input logic [DATA_W-1:0] rd, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [DATA_W-1:0] sh;
        sh = rd >> {lane, 3'b000};
        case (size)
            2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    assign w_lane = f_lane(bus.d_addr[1:0], bus.d_size);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((bus.d_size == 2'b01) & bus.d_addr[0]) |
                        (bus.d_size[1] & (bus.d_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Core is held off while either requester is waiting for its ack
    assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

    // Arbitration FSM and all registered memory / response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gnt_d       <= 1'b0;
            r_lane        <= 2'b00;
            r_size        <= 2'b00;
            r_sign        <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= 4'b0000;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.d_req) begin
                        r_gnt_d <= 1'b1;
                        r_lane  <= w_lane;
                        r_size  <= bus.d_size;
                        r_sign  <= bus.d_ext_sign;
                        if (w_misalign) begin
                            // Trap: answer straight away, memory is never touched
                            bus.d_ack   <= 1'b1;
                            bus.d_err   <= 1'b1;
                            bus.d_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_wdata <= f_wrep(bus.d_wdata, bus.d_size);
                            bus.mem_be    <= f_be(w_lane, bus.d_size);
                            r_state       <= S_BUSY;
                        end
                    end else if (bus.if_req) begin
                        r_gnt_d       <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_be    <= 4'b1111;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (r_gnt_d) begin
                            bus.d_rdata <= f_load(bus.mem_rdata, r_lane, r_size, r_sign);
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ack   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.d_err  <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (optional MISALIGN_TRAP_EN aware).
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data transaction with mem_ready held high; reports result and latency
    task automatic dxfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input logic [31:0] rdata,
                         output logic [31:0] got, output logic err, output int lat,
                         output logic saw_req, output logic [31:0] maddr, output logic [3:0] mbe);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_size = size;
        bus.d_ext_sign = sgn; bus.d_wdata = wdata;
        bus.mem_ready = 1'b1; bus.mem_rdata = rdata;
        lat = 0; saw_req = 1'b0; maddr = '0; mbe = '0; got = '0; err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.mem_req && !saw_req) begin
                saw_req = 1'b1; maddr = bus.mem_addr; mbe = bus.mem_be;
            end
            if (bus.d_ack) begin
                lat = i; got = bus.d_rdata; err = bus.d_err;
                break;
            end
        end
        if (lat == 0) chk("d_ack_timeout", 32'd0, 32'd1);
        bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
    endtask

    logic [31:0] got, maddr;
    logic        err, saw;
    logic [3:0]  mbe;
    int          lat, d_cnt, i_cnt, d_cyc, i_cyc, ack_cnt;
    logic [31:0] first_addr;
    logic        stall_mid;

    initial begin
        n_tests = 0; n_fail = 0;
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_size = 2'b00; bus.d_ext_sign = 0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_acks", {29'd0, bus.if_ack, bus.d_ack, bus.d_err}, 32'd0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch, zero wait (mem_ready already high in IDLE is ignored)
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
        #1;
        chk("f_stall_c0", {31'd0, bus.stall}, 32'd1);
        chk("f_mem_req_c0", {31'd0, bus.mem_req}, 32'd0);
        tick();
        chk("f_mem_req_c1", {31'd0, bus.mem_req}, 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_be", {28'd0, bus.mem_be}, 32'hF);
        chk("f_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("f_stall_c1", {31'd0, bus.stall}, 32'd1);
        chk("f_ack_c1", {31'd0, bus.if_ack}, 32'd0);
        tick();
        chk("f_ack_c2", {31'd0, bus.if_ack}, 32'd1);
        chk("f_rdata", bus.if_rdata, 32'h00500093);
        chk("f_stall_c2", {31'd0, bus.stall}, 32'd0);
        chk("f_mem_req_c2", {31'd0, bus.mem_req}, 32'd0);
        bus.if_req = 0; bus.mem_ready = 0;
        tick();
        chk("f_ack_c3", {31'd0, bus.if_ack}, 32'd0);

        // Store byte at 0x203 with 3 wait cycles
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h203; bus.d_size = 2'b00;
        bus.d_wdata = 32'h000000AB; bus.mem_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("sb_req_c%0d", c), {31'd0, bus.mem_req}, 32'd1);
            chk($sformatf("sb_addr_c%0d", c), bus.mem_addr, 32'h200);
            chk($sformatf("sb_be_c%0d", c), {28'd0, bus.mem_be}, 32'h8);
            chk($sformatf("sb_wdata_c%0d", c), bus.mem_wdata, 32'hABABABAB);
            chk($sformatf("sb_we_c%0d", c), {31'd0, bus.mem_we}, 32'd1);
            chk($sformatf("sb_ack_c%0d", c), {31'd0, bus.d_ack}, 32'd0);
        end
        bus.mem_ready = 1;
        tick();
        chk("sb_ack", {31'd0, bus.d_ack}, 32'd1);
        chk("sb_err", {31'd0, bus.d_err}, 32'd0);
        chk("sb_req_done", {31'd0, bus.mem_req}, 32'd0);
        bus.d_req = 0; bus.mem_ready = 0; bus.d_we = 0;
        tick();
        chk("sb_ack_once", {31'd0, bus.d_ack}, 32'd0);

        // Store half at 0x406 -> upper lanes, replicated
        dxfer(1, 32'h406, 2'b01, 0, 32'h0000BEEF, 32'h0, got, err, lat, saw, maddr, mbe);
        chk("sh_be", {28'd0, mbe}, 32'hC);
        chk("sh_addr", maddr, 32'h404);

        // Loads
        dxfer(0, 32'h402, 2'b01, 1, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lh_s_data", got, 32'hFFFF8001);
        chk("lh_s_lat", lat, 32'd2);
        chk("lh_s_be", {28'd0, mbe}, 32'hC);
        dxfer(0, 32'h402, 2'b01, 0, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lh_u_data", got, 32'h00008001);
        dxfer(0, 32'h401, 2'b00, 0, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lb_u_data", got, 32'h00000012);
        chk("lb_u_be", {28'd0, mbe}, 32'h2);
        dxfer(0, 32'h403, 2'b00, 1, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lb_s_data", got, 32'hFFFFFF80);
        dxfer(0, 32'h400, 2'b10, 1, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lw_data", got, 32'h80011234);
        dxfer(0, 32'h400, 2'b11, 0, 32'h0, 32'h80011234, got, err, lat, saw, maddr, mbe);
        chk("lw11_data", got, 32'h80011234);
        chk("lw11_be", {28'd0, mbe}, 32'hF);

        // Contention: data wins, fetch served after one IDLE cycle
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.d_size = 2'b10; bus.d_ext_sign = 0;
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.mem_ready = 1; bus.mem_rdata = 32'h13579BDF;
        d_cnt = 0; i_cnt = 0; d_cyc = 0; i_cyc = 0; first_addr = '0; stall_mid = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) first_addr = bus.mem_addr;
            if (c == 3) stall_mid = bus.stall;
            if (bus.d_ack) begin d_cnt++; d_cyc = c; bus.d_req = 0; end
            if (bus.if_ack) begin i_cnt++; i_cyc = c; bus.if_req = 0; end
        end
        bus.mem_ready = 0;
        chk("ct_first_addr", first_addr, 32'h500);
        chk("ct_d_cnt", d_cnt, 32'd1);
        chk("ct_i_cnt", i_cnt, 32'd1);
        chk("ct_d_cyc", d_cyc, 32'd2);
        chk("ct_i_cyc", i_cyc, 32'd5);
        chk("ct_stall_idle", {31'd0, stall_mid}, 32'd1);

        // Reset in the middle of a load wait
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h600; bus.d_size = 2'b10; bus.mem_ready = 0;
        tick();
        tick();
        chk("rb_busy_req", {31'd0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_req_async", {31'd0, bus.mem_req}, 32'd0);
        ack_cnt = 0;
        bus.mem_ready = 1;
        tick();
        if (bus.d_ack) ack_cnt++;
        bus.d_req = 0;
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.d_ack) ack_cnt++;
        end
        chk("rb_no_ack", ack_cnt, 32'd0);
        chk("rb_idle_req", {31'd0, bus.mem_req}, 32'd0);
        bus.if_req = 1; bus.if_addr = 32'h0; bus.mem_rdata = 32'hDEADBEEF; bus.mem_ready = 1;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.if_ack) begin lat = c; got = bus.if_rdata; break; end
        end
        chk("rb_fetch_lat", lat, 32'd2);
        chk("rb_fetch_data", got, 32'hDEADBEEF);
        bus.if_req = 0; bus.mem_ready = 0;
        tick();

        // Misaligned word load at 0x302
        dxfer(0, 32'h302, 2'b10, 0, 32'h0, 32'hCAFEF00D, got, err, lat, saw, maddr, mbe);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lat", lat, 32'd1);
        chk("mis_no_req", {31'd0, saw}, 32'd0);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_data", got, 32'd0);
`else
        chk("mis_lat", lat, 32'd2);
        chk("mis_addr", maddr, 32'h300);
        chk("mis_be", {28'd0, mbe}, 32'hF);
        chk("mis_err", {31'd0, err}, 32'd0);
        chk("mis_data", got, 32'hCAFEF00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch and the load/store path of the RISC-V core.
- Arbitrates between the two requesters and sequences a variable-latency memory handshake.
- Generates byte enables and store-data lane replication.
- Extracts and sign- or zero-extends load data, and produces a core stall while any access is outstanding.

Parameters:
ADDR_W, 32, byte address width of all address ports
DATA_W, 32, memory data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch byte address (word aligned)
if_rdata  out  32  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
d_ext_sign  in  1  1 = sign-extend load, 0 = zero-extend
d_rdata  out  32  aligned, extended load data, valid while d_ack=1
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  misaligned-access flag, valid with d_ack
mem_req  out  1  memory request, registered
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address: {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1
stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack)

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, d_err, if_rdata, d_rdata. Any in-flight transaction is abandoned with no ack.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE, arbitration:
  - Data has fixed priority over fetch; the data access belongs to the current instruction.
  - If d_req=1, grant data; else if if_req=1, grant fetch.
  - On grant, latch address/we/size/ext_sign/wdata, drive mem_* registered, and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_req=1 and all mem_* outputs stay stable until mem_ready=1.
  - On mem_ready=1, capture mem_rdata, deassert mem_req, and go to RESP. Any number of wait states is allowed.
- RESP:
  - The granted requester's ack=1 for exactly one cycle, with rdata valid; then go to IDLE.
  - The requester must drop req on the cycle after ack. The IDLE cycle after RESP is the first point where a new grant can occur.
- Minimum latency: req sampled at cycle 0, mem_req at cycle 1; mem_ready at cycle 1 gives ack at cycle 2. Each mem_ready wait cycle adds 1.
- mem_ready while in IDLE or RESP is ignored.
- Fetch accesses: mem_we=0, mem_be=1111, if_rdata=mem_rdata unmodified.
- Byte enables, with a = addr[1:0]:
  - byte: 0001 << a
  - half: a[1] ? 1100 : 0011
  - word: 1111
- Store data replication, with w = d_wdata:
  - byte: {4{w[7:0]}}
  - half: {2{w[15:0]}}
  - word: w
- Loads: d_rdata = (mem_rdata >> 8*a), then truncated to the access size and extended per d_ext_sign. Word loads are returned unextended.
- mem_be is also driven on loads; memory may ignore it.
- Simultaneous requests: d_req and if_req both high in IDLE grants data. Fetch is served in the next IDLE window, so stall stays high throughout.
- A request that rises while in BUSY or RESP is held and served in the next IDLE window.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A data access is misaligned if it is a half with a[0]=1, or a word with a!=00.
  - A misaligned grant goes IDLE->RESP directly, with no mem_req.
  - Response: d_ack=1, d_err=1, d_rdata=0; no store is performed.
- Undefined:
  - d_err is tied to 0.
  - Misaligned accesses proceed: a[0] is ignored for half, a is ignored for word (be=1111, no shift).

Test Plan:
- Fetch, zero wait: if_req=1, if_addr=0x100, mem_ready=1 immediately, mem_rdata=0x00500093 -> mem_req at cycle 1, mem_addr=0x100, mem_be=1111; if_ack at cycle 2 with if_rdata=0x00500093; stall high at cycles 0-1.
- Store byte with waits: d_we=1, d_addr=0x203, d_size=00, d_wdata=0x000000AB, mem_ready after 3 cycles -> mem_addr=0x200, mem_be=1000, mem_wdata=0xABABABAB, all held stable for 3 cycles; d_ack one cycle later.
- Load half signed: d_addr=0x402, d_size=01, d_ext_sign=1, mem_rdata=0x8001_1234 -> d_rdata=0xFFFF8001. Same with d_ext_sign=0 -> 0x00008001. Byte at 0x401, zero-extended -> 0x00000012.
- Contention: if_req and d_req both rise in the same IDLE cycle -> data transaction first, d_ack, one IDLE cycle, then the fetch transaction; exactly one ack per requester.
- Reset mid-BUSY: assert rst_n=0 during a load wait -> mem_req drops immediately with no clock edge; no d_ack; after release, state is IDLE and a new fetch completes normally.
- Misaligned: word load at 0x302 -> with MISALIGN_TRAP_EN: no mem_req, d_ack+d_err at cycle 1, d_rdata=0. Without it: mem_addr=0x300, mem_be=1111, d_err=0.
